// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port data memory arbiter (IDLE/ACCESS/RESP)
// Optional misaligned-access check: define DMEM_ARB_MISALIGN_CHECK_EN.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [DM_ADDRESS-1:0] r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    input  logic [2:0]            r0_funct3,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [DM_ADDRESS-1:0] r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    input  logic [2:0]            r1_funct3,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,
    output logic                  r0_err,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_rdata,
    output logic                  r1_err,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   last;
    logic   owner;
    logic   lat_we;

    logic                  can_grant;
    logic                  any_gnt;
    logic                  gsel;
    logic                  s_we;
    logic [DM_ADDRESS-1:0] s_addr;
    logic [DATA_W-1:0]     s_wdata;
    logic [2:0]            s_f3;

    // Grants are combinational so the command is sampled in the gnt cycle.
    assign can_grant = !reset && (state == IDLE || state == RESP);
    assign r0_gnt    = can_grant && r0_req && (!r1_req || last);
    assign r1_gnt    = can_grant && r1_req && (!r0_req || !last);
    assign any_gnt   = r0_gnt || r1_gnt;
    assign gsel      = r1_gnt;

    assign s_we    = gsel ? r1_we     : r0_we;
    assign s_addr  = gsel ? r1_addr   : r0_addr;
    assign s_wdata = gsel ? r1_wdata  : r0_wdata;
    assign s_f3    = gsel ? r1_funct3 : r0_funct3;

    assign MemRead   = (state == ACCESS) && !lat_we;
    assign MemWrite  = (state == ACCESS) && lat_we;
    assign r0_rvalid = (state == RESP) && !owner;
    assign r1_rvalid = (state == RESP) && owner;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    logic err_q;
    logic mis;

    assign mis    = ((s_f3 == 3'b010) && (s_addr[1:0] != 2'b00)) ||
                    ((s_f3 == 3'b001) && s_addr[0]);
    assign r0_err = r0_rvalid && err_q;
    assign r1_err = r1_rvalid && err_q;
`else
    assign r0_err = 1'b0;
    assign r1_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            lat_we   <= 1'b0;
            a        <= '0;
            wd       <= '0;
            Funct3   <= '0;
            r0_rdata <= '0;
            r1_rdata <= '0;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ACCESS: begin
                    if (owner) r1_rdata <= lat_we ? '0 : rd;
                    else       r0_rdata <= lat_we ? '0 : rd;
                    state <= RESP;
                end
                default: begin
                    if (any_gnt) begin
                        owner  <= gsel;
                        last   <= gsel;
                        lat_we <= s_we;
                        a      <= s_addr;
                        wd     <= s_wdata;
                        Funct3 <= s_f3;
                        state  <= ACCESS;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
                        err_q <= mis;
                        // Misaligned accesses never reach memory; answer next cycle.
                        if (mis) begin
                            if (gsel) r1_rdata <= '0;
                            else      r0_rdata <= '0;
                            state <= RESP;
                        end
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester controller sharing the single data memory between the core load/store path (port 0) and a loader/debug port (port 1). Grants one access at a time with round-robin arbitration and sequences the memory's MemRead/MemWrite/address/data/Funct3 controls through an IDLE → ACCESS → RESP state machine. Returns the read data or a write acknowledge to the granted requester. Sits between the requesters and the data memory; the memory's byte/halfword formatting by Funct3 is unchanged.

## Interface
- DM_ADDRESS, 9, width of the memory byte address.
- DATA_W, 32, data word width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req / r1_req  in  1  request valid; held until the same-port gnt is seen.
- r0_we / r1_we  in  1  1 = store, 0 = load.
- r0_addr / r1_addr  in  DM_ADDRESS  byte address.
- r0_wdata / r1_wdata  in  DATA_W  store data.
- r0_funct3 / r1_funct3  in  3  access size/sign (010 word, 001 half, 000 byte, 100 byte unsigned).
- r0_gnt / r1_gnt  out  1  one-cycle accept pulse; command sampled this cycle.
- r0_rvalid / r1_rvalid  out  1  one-cycle response pulse (load data or store ack).
- r0_rdata / r1_rdata  out  DATA_W  load result; valid with rvalid; 0 for stores.
- r0_err / r1_err  out  1  misaligned-access flag, valid with rvalid.
- MemRead  out  1  to data memory.
- MemWrite  out  1  to data memory.
- a  out  DM_ADDRESS  to data memory.
- wd  out  DATA_W  to data memory.
- Funct3  out  3  to data memory.
- rd  in  DATA_W  from data memory (combinational read data).

## Operation
- States: IDLE, ACCESS, RESP. Reset → IDLE.
- Grant: permitted in IDLE or RESP. If exactly one req is high, that port is granted. If both are high, the port not served last wins. Last-served pointer resets to port 1, so port 0 wins the first tie. The pointer updates on every grant.
- On grant: latch we, addr, wdata, funct3 and owner id; pulse owner gnt; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive a/wd/Funct3 from the latch.
  - MemRead = ~we, MemWrite = we. The two are never both 1.
  - Capture rd into the owner's rdata register at the clock edge ending the cycle.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse owner rvalid; rdata is held until the next response.
  - If a req is pending, grant it in this same cycle and go to ACCESS; else go to IDLE.
- Outside ACCESS: MemRead = MemWrite = 0. a/wd/Funct3 hold their last latched values (0 after reset).
- A req deasserted before gnt is dropped; no access occurs.
- Non-owner port sees no gnt or rvalid.
- Reset values: all gnt/rvalid/err = 0, rdata = 0, MemRead = MemWrite = 0, a = wd = Funct3 = 0, pointer = port 1.

## Timing
- Request accepted at cycle T (gnt = 1). Memory is driven at T+1. rvalid and rdata appear at T+2.
- Back-to-back requests: one access per 2 cycles (a grant in RESP overlaps the prior response).
- Store commits within the ACCESS cycle (memory writes on the falling clock edge).
- Reset sampled high in any state: next cycle is IDLE with reset values and no rvalid for the abandoned access. A store whose ACCESS cycle coincides with the reset cycle still commits (MemWrite is state-decoded in that cycle).
- req high during reset is ignored. Grants start the cycle after reset deasserts.

## Configuration
- DMEM_ARB_MISALIGN_CHECK_EN defined:
  - At grant, the access is misaligned if funct3 = 010 with addr[1:0] ≠ 0, or funct3 = 001 with addr[0] = 1.
  - A misaligned access skips ACCESS: IDLE/RESP → RESP directly. MemRead and MemWrite are never asserted, and the response carries err = 1, rdata = 0. Latency is T+1.
- Not defined: r0_err = r1_err = 0 constant. All accesses go to memory unchecked; the memory ignores the low address bits as it does today.

## Test plan
- Port 0 stores 0xDEADBEEF at 0x010, then loads 010 from 0x010. Expect gnt at T, MemWrite = 1 only at T+1, r0_rvalid at T+2, then the load returns 0xDEADBEEF.
- r0_req and r1_req both high from reset release for 4 accesses. Expect grants in the order 0, 1, 0, 1, and throughput of one access per 2 cycles.
- Port 1 does SB 0x80 at 0x013 then LB at 0x013. Expect r1_rdata = 0xFFFFFF80. LBU at 0x013 returns 0x00000080. Port 0 is idle and sees no pulses.
- Assert reset during the ACCESS cycle of a port 0 load. Expect no r0_rvalid, all outputs at reset values the next cycle, and correct service of the next request.
- Macro defined: LW at 0x006. Expect rvalid at T+1 with err = 1, rdata = 0, and MemRead never asserted. Macro undefined: the same access returns the word at 0x004 with err = 0.
